// File: rtl/control_sequencer.sv
// control_sequencer: hardwired multi-cycle control unit (fetch T0-T2, execute E1-E5) for the bus datapath.
// Optional build macro SINGLE_STEP_EN adds a step input and an IDLE state gating each instruction.
module control_sequencer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    input  logic        stop,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic [3:0]  bus_src,
    output logic [1:0]  reg_sel,
    output logic [10:0] ld_en,
    output logic        inc_pc,
    output logic [4:0]  alu_op,
    output logic        mem_read,
    output logic        mem_write,
    output logic        run,
    output logic        error
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [3:0] BUS_PC  = 4'd1, BUS_ZLO = 4'd2, BUS_ZHI = 4'd3, BUS_MDR = 4'd4,
                           BUS_HI  = 4'd5, BUS_LO  = 4'd6, BUS_IN  = 4'd7, BUS_C   = 4'd8,
                           BUS_GPR = 4'd9;
    localparam logic [1:0] SEL_RA = 2'd1, SEL_RB = 2'd2, SEL_RC = 2'd3;
    localparam int LD_PC = 0, LD_IR = 1, LD_MAR = 2, LD_MDR = 3, LD_Y = 4, LD_Z = 5,
                   LD_HI = 6, LD_LO = 7, LD_OUT = 8, LD_CON = 9, LD_GPR = 10;
    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [3:0] {
        T0, T1, T2, E1, E2, E3, E4, E5, HALT
`ifdef SINGLE_STEP_EN
        , IDLE
`endif
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_IMM, C_UNARY, C_MULDIV, C_LDI, C_LD, C_ST, C_BR,
        C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
    } cls_t;

`ifdef SINGLE_STEP_EN
    localparam state_t NEXT_INSTR = IDLE;
    logic stepQ;
`else
    localparam state_t NEXT_INSTR = T0;
`endif

    state_t        state;
    logic          errorQ;
    logic [CW-1:0] waitCnt;
    logic [4:0]    opReg;
    logic [4:0]    op;
    cls_t          opClass;
    logic          waitLast;
    logic          unusedIrFields;

    // Register fields are selected downstream through reg_sel; only the opcode is decoded here.
    assign unusedIrFields = ^ir[26:0];

    function automatic cls_t classOf(input logic [4:0] code);
        cls_t c;
        c = C_ILL;
        if (code >= 5'd3 && code <= 5'd11)       c = C_RTYPE;
        else if (code >= 5'd12 && code <= 5'd14) c = C_IMM;
        else begin
            case (code)
                5'd0:         c = C_LD;
                5'd1:         c = C_LDI;
                5'd2:         c = C_ST;
                5'd15, 5'd16: c = C_MULDIV;
                5'd17, 5'd18: c = C_UNARY;
                5'd19:        c = C_BR;
                5'd22:        c = C_IN;
                5'd23:        c = C_OUT;
                5'd24:        c = C_MFHI;
                5'd25:        c = C_MFLO;
                5'd26:        c = C_NOP;
                5'd27:        c = C_HALT;
                default:      c = C_ILL;
            endcase
        end
        return c;
    endfunction

    // IR is decoded live in E1 and held in opReg for the remaining execute steps.
    assign op       = (state == E1) ? ir[31:27] : opReg;
    assign opClass  = classOf(op);
    assign waitLast = (waitCnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= NEXT_INSTR;
            errorQ  <= 1'b0;
            waitCnt <= '0;
            opReg   <= '0;
`ifdef SINGLE_STEP_EN
            stepQ   <= 1'b0;
`endif
        end else begin
            waitCnt <= '0;
`ifdef SINGLE_STEP_EN
            stepQ   <= step;
`endif
            case (state)
                T0: state <= stop ? HALT : T1;
                T1: begin
                    if (mem_ready) state <= T2;
                    else if (waitLast) begin
                        state  <= HALT;
                        errorQ <= 1'b1;
                    end else waitCnt <= waitCnt + CW'(1);
                end
                T2: state <= E1;
                E1: begin
                    opReg <= ir[31:27];
                    case (opClass)
                        C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP: state <= NEXT_INSTR;
                        C_HALT: state <= HALT;
                        C_ILL: begin
                            state  <= HALT;
                            errorQ <= 1'b1;
                        end
                        default: state <= E2;
                    endcase
                end
                E2: state <= (opClass == C_UNARY) ? NEXT_INSTR : E3;
                E3: begin
                    if (opClass == C_MULDIV || opClass == C_LD || opClass == C_ST || opClass == C_BR)
                        state <= E4;
                    else
                        state <= NEXT_INSTR;
                end
                E4: begin
                    if (opClass == C_ST) state <= E5;
                    else if (opClass == C_LD) begin
                        if (mem_ready) state <= E5;
                        else if (waitLast) begin
                            state  <= HALT;
                            errorQ <= 1'b1;
                        end else waitCnt <= waitCnt + CW'(1);
                    end else state <= NEXT_INSTR;
                end
                E5: begin
                    if (opClass != C_ST || mem_ready) state <= NEXT_INSTR;
                    else if (waitLast) begin
                        state  <= HALT;
                        errorQ <= 1'b1;
                    end else waitCnt <= waitCnt + CW'(1);
                end
`ifdef SINGLE_STEP_EN
                IDLE: begin
                    if (stop) state <= HALT;
                    else if (step && !stepQ) state <= T0;
                end
`endif
                default: state <= HALT;
            endcase
        end
    end

    // Outputs decode the registered state; a clr cycle forces every output low.
    always_comb begin
        bus_src   = '0;
        reg_sel   = '0;
        ld_en     = '0;
        inc_pc    = 1'b0;
        alu_op    = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        run       = 1'b0;
        error     = 1'b0;
        if (!clr) begin
            run   = (state != HALT);
            error = errorQ;
            case (state)
                T0: if (!stop) begin
                    bus_src        = BUS_PC;
                    ld_en[LD_MAR]  = 1'b1;
                    ld_en[LD_Z]    = 1'b1;
                    inc_pc         = 1'b1;
                end
                T1: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        bus_src       = BUS_ZLO;
                        ld_en[LD_PC]  = 1'b1;
                        ld_en[LD_MDR] = 1'b1;
                    end
                end
                T2: begin
                    bus_src      = BUS_MDR;
                    ld_en[LD_IR] = 1'b1;
                end
                E1: case (opClass)
                    C_RTYPE, C_IMM, C_LDI, C_LD, C_ST: begin
                        bus_src = BUS_GPR; reg_sel = SEL_RB; ld_en[LD_Y] = 1'b1;
                    end
                    C_UNARY: begin
                        bus_src = BUS_GPR; reg_sel = SEL_RB; alu_op = op; ld_en[LD_Z] = 1'b1;
                    end
                    C_MULDIV: begin
                        bus_src = BUS_GPR; reg_sel = SEL_RA; ld_en[LD_Y] = 1'b1;
                    end
                    C_BR: begin
                        bus_src = BUS_GPR; reg_sel = SEL_RA; ld_en[LD_CON] = 1'b1;
                    end
                    C_IN:   begin bus_src = BUS_IN; reg_sel = SEL_RA; ld_en[LD_GPR] = 1'b1; end
                    C_OUT:  begin bus_src = BUS_GPR; reg_sel = SEL_RA; ld_en[LD_OUT] = 1'b1; end
                    C_MFHI: begin bus_src = BUS_HI; reg_sel = SEL_RA; ld_en[LD_GPR] = 1'b1; end
                    C_MFLO: begin bus_src = BUS_LO; reg_sel = SEL_RA; ld_en[LD_GPR] = 1'b1; end
                    default: ;
                endcase
                E2: case (opClass)
                    C_RTYPE: begin
                        bus_src = BUS_GPR; reg_sel = SEL_RC; alu_op = op; ld_en[LD_Z] = 1'b1;
                    end
                    C_IMM: begin bus_src = BUS_C; alu_op = op; ld_en[LD_Z] = 1'b1; end
                    C_LDI, C_LD, C_ST: begin bus_src = BUS_C; alu_op = ALU_ADD; ld_en[LD_Z] = 1'b1; end
                    C_UNARY: begin bus_src = BUS_ZLO; reg_sel = SEL_RA; ld_en[LD_GPR] = 1'b1; end
                    C_MULDIV: begin
                        bus_src = BUS_GPR; reg_sel = SEL_RB; alu_op = op; ld_en[LD_Z] = 1'b1;
                    end
                    C_BR: begin bus_src = BUS_PC; ld_en[LD_Y] = 1'b1; end
                    default: ;
                endcase
                E3: case (opClass)
                    C_RTYPE, C_IMM, C_LDI: begin
                        bus_src = BUS_ZLO; reg_sel = SEL_RA; ld_en[LD_GPR] = 1'b1;
                    end
                    C_LD, C_ST: begin bus_src = BUS_ZLO; ld_en[LD_MAR] = 1'b1; end
                    C_MULDIV:   begin bus_src = BUS_ZLO; ld_en[LD_LO] = 1'b1; end
                    C_BR:       begin bus_src = BUS_C; alu_op = ALU_ADD; ld_en[LD_Z] = 1'b1; end
                    default: ;
                endcase
                E4: case (opClass)
                    C_LD: begin
                        mem_read      = 1'b1;
                        ld_en[LD_MDR] = mem_ready;
                    end
                    C_ST:     begin bus_src = BUS_GPR; reg_sel = SEL_RA; ld_en[LD_MDR] = 1'b1; end
                    C_MULDIV: begin bus_src = BUS_ZHI; ld_en[LD_HI] = 1'b1; end
                    C_BR: if (con_ff) begin bus_src = BUS_ZLO; ld_en[LD_PC] = 1'b1; end
                    default: ;
                endcase
                E5: case (opClass)
                    C_LD: begin bus_src = BUS_MDR; reg_sel = SEL_RA; ld_en[LD_GPR] = 1'b1; end
                    C_ST: mem_write = 1'b1;
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction step lists built from the instruction-class rules,
// driven cycle by cycle with random handshake timing, aborts, stops and illegal opcodes.
module tb_control_sequencer;

    localparam int TO = 4;
    localparam logic [4:0] ADD = 5'd3;
    localparam logic [10:0] L_PC = 11'h001, L_IR = 11'h002, L_MAR = 11'h004, L_MDR = 11'h008,
                            L_Y = 11'h010, L_Z = 11'h020, L_HI = 11'h040, L_LO = 11'h080,
                            L_OUT = 11'h100, L_CON = 11'h200, L_GPR = 11'h400;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] ir = '0;
    logic        con_ff = 1'b0;
    logic        mem_ready = 1'b0;
    logic        stop = 1'b0;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b0;
`endif
    logic [3:0]  bus_src;
    logic [1:0]  reg_sel;
    logic [10:0] ld_en;
    logic        inc_pc;
    logic [4:0]  alu_op;
    logic        mem_read;
    logic        mem_write;
    logic        run;
    logic        error;

    control_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .bus_src(bus_src), .reg_sel(reg_sel), .ld_en(ld_en), .inc_pc(inc_pc), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .run(run), .error(error)
    );

    always #5 clk = ~clk;

    wire [26:0] actual = {bus_src, reg_sel, ld_en, inc_pc, alu_op, mem_read, mem_write, run, error};

    logic [26:0] exp_q[$];
    logic [2:0]  drv_q[$];
    string       tag_q[$];
    int          nCmp = 0;
    int          nBad = 0;
    int          txn = 0;
    logic        forceStop = 1'b0;

    task automatic checkVal(input string tag, input logic [26:0] got, input logic [26:0] want);
        nCmp++;
        if (got !== want) begin
            nBad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic coin();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [26:0] pk(input logic [3:0] b, input logic [1:0] s, input logic [10:0] l,
                                       input logic [4:0] a, input logic inc, input logic mr,
                                       input logic mw, input logic rn, input logic er);
        return {b, s, l, inc, a, mr, mw, rn, er};
    endfunction

    task automatic pushFull(input string tag, input logic [26:0] e, input logic mr, input logic cf,
                            input logic st);
        exp_q.push_back(e);
        drv_q.push_back({mr, cf, st});
        tag_q.push_back(tag);
    endtask

    // A non-wait step: handshake inputs are noise there and stop must not act mid-instruction.
    task automatic pushStep(input string tag, input logic [3:0] b, input logic [1:0] s,
                            input logic [10:0] l, input logic [4:0] a);
        pushFull(tag, pk(b, s, l, a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), coin(), coin(), forceStop | coin());
    endtask

    task automatic pushHalt(input logic er);
        for (int i = 0; i < 2; i++)
            pushFull("halt", pk(4'd0, 2'd0, 11'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, er), coin(), coin(), coin());
    endtask

    // d idle cycles before ready; d >= TO means the request times out into HALT with error.
    task automatic pushWait(input string tag, input int d, input logic wr, input logic [3:0] rdyBus,
                            input logic [10:0] rdyLd, output logic ok);
        int n;
        n = (d < TO) ? d : TO;
        for (int i = 0; i < n; i++)
            pushFull(tag, pk(4'd0, 2'd0, 11'd0, 5'd0, 1'b0, !wr, wr, 1'b1, 1'b0), 1'b0, coin(), coin());
        if (d < TO) begin
            pushFull({tag, "-rdy"}, pk(rdyBus, 2'd0, rdyLd, 5'd0, 1'b0, !wr, wr, 1'b1, 1'b0), 1'b1, coin(), coin());
            ok = 1'b1;
        end else begin
            pushHalt(1'b1);
            ok = 1'b0;
        end
    endtask

    task automatic buildInstr(input logic [4:0] op, input logic con, input int d1, input int d2,
                              input logic stopNext, output logic halted);
        logic ok;
        halted = 1'b0;
        pushFull("t0", pk(4'd1, 2'd0, L_MAR | L_Z, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0), coin(), coin(), 1'b0);
        pushWait("t1", d1, 1'b0, 4'd2, L_PC | L_MDR, ok);
        if (!ok) begin halted = 1'b1; return; end
        pushStep("t2", 4'd4, 2'd0, L_IR, 5'd0);
        if (op <= 5'd14) begin
            pushStep("e1", 4'd9, 2'd2, L_Y, 5'd0);
            if (op >= 5'd3 && op <= 5'd11) pushStep("e2", 4'd9, 2'd3, L_Z, op);
            else pushStep("e2", 4'd8, 2'd0, L_Z, (op >= 5'd12) ? op : ADD);
            if (op == 5'd0) begin
                pushStep("e3", 4'd2, 2'd0, L_MAR, 5'd0);
                pushWait("e4", d2, 1'b0, 4'd0, L_MDR, ok);
                if (!ok) begin halted = 1'b1; return; end
                pushStep("e5", 4'd4, 2'd1, L_GPR, 5'd0);
            end else if (op == 5'd2) begin
                pushStep("e3", 4'd2, 2'd0, L_MAR, 5'd0);
                pushStep("e4", 4'd9, 2'd1, L_MDR, 5'd0);
                pushWait("e5", d2, 1'b1, 4'd0, 11'd0, ok);
                if (!ok) begin halted = 1'b1; return; end
            end else pushStep("e3", 4'd2, 2'd1, L_GPR, 5'd0);
        end else begin
            case (op)
                5'd15, 5'd16: begin
                    pushStep("e1", 4'd9, 2'd1, L_Y, 5'd0);
                    pushStep("e2", 4'd9, 2'd2, L_Z, op);
                    pushStep("e3", 4'd2, 2'd0, L_LO, 5'd0);
                    pushStep("e4", 4'd3, 2'd0, L_HI, 5'd0);
                end
                5'd17, 5'd18: begin
                    pushStep("e1", 4'd9, 2'd2, L_Z, op);
                    pushStep("e2", 4'd2, 2'd1, L_GPR, 5'd0);
                end
                5'd19: begin
                    pushStep("e1", 4'd9, 2'd1, L_CON, 5'd0);
                    pushStep("e2", 4'd1, 2'd0, L_Y, 5'd0);
                    pushStep("e3", 4'd8, 2'd0, L_Z, ADD);
                    pushFull("e4br", con ? pk(4'd2, 2'd0, L_PC, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)
                                         : pk(4'd0, 2'd0, 11'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0),
                             coin(), con, coin());
                end
                5'd22: pushStep("e1in", 4'd7, 2'd1, L_GPR, 5'd0);
                5'd23: pushStep("e1out", 4'd9, 2'd1, L_OUT, 5'd0);
                5'd24: pushStep("e1hi", 4'd5, 2'd1, L_GPR, 5'd0);
                5'd25: pushStep("e1lo", 4'd6, 2'd1, L_GPR, 5'd0);
                5'd26: pushStep("e1nop", 4'd0, 2'd0, 11'd0, 5'd0);
                5'd27: begin
                    pushStep("e1halt", 4'd0, 2'd0, 11'd0, 5'd0);
                    pushHalt(1'b0);
                    halted = 1'b1;
                    return;
                end
                default: begin
                    pushStep("e1ill", 4'd0, 2'd0, 11'd0, 5'd0);
                    pushHalt(1'b1);
                    halted = 1'b1;
                    return;
                end
            endcase
        end
        if (stopNext) begin
            pushFull("t0stop", pk(4'd0, 2'd0, 11'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), coin(), coin(), 1'b1);
            pushHalt(1'b0);
            halted = 1'b1;
        end
    endtask

    // Called at posedge+1; each entry drives inputs, checks at the falling edge, then advances.
    task automatic execQueue(input int limit);
        int k;
        logic [2:0] d;
        logic [26:0] e;
        string t;
        k = 0;
        while (exp_q.size() > 0 && k < limit) begin
            d = drv_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            {mem_ready, con_ff, stop} = d;
            @(negedge clk);
            checkVal($sformatf("tx%0d %s", txn, t), actual, e);
            @(posedge clk);
            #1;
            k++;
        end
        exp_q.delete();
        drv_q.delete();
        tag_q.delete();
    endtask

    task automatic doReset();
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {mem_ready, con_ff, stop} = {coin(), coin(), coin()};
            @(negedge clk);
            checkVal($sformatf("tx%0d clr", txn), actual, 27'd0);
            @(posedge clk);
            #1;
        end
        clr = 1'b0;
    endtask

    task automatic runTxn(input logic [31:0] instr, input logic con, input int d1, input int d2,
                          input logic stopNext, input logic abortOk);
        logic halted;
        int total;
        int limit;
        ir = instr;
        buildInstr(instr[31:27], con, d1, d2, stopNext, halted);
        total = exp_q.size();
        limit = total;
        if (abortOk && total > 1) limit = int'($urandom_range(1, total - 1));
        execQueue(limit);
        if (halted || limit < total) doReset();
        txn++;
    endtask

    function automatic int randDelay();
        return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(4, 5));
    endfunction

    initial begin
        @(posedge clk);
        #1;
        doReset();
        runTxn(32'h18918000, 1'b0, 0, 0, 1'b0, 1'b0);
        runTxn({5'd0, 4'd4, 4'd5, 19'h10}, 1'b0, 0, 3, 1'b0, 1'b0);
        runTxn({5'd19, 4'd1, 4'd0, 19'h7}, 1'b0, 1, 0, 1'b0, 1'b0);
        runTxn({5'd19, 4'd1, 4'd0, 19'h7}, 1'b1, 0, 0, 1'b0, 1'b0);
        runTxn({5'd15, 4'd2, 4'd3, 19'h0}, 1'b0, 2, 0, 1'b0, 1'b0);
        runTxn({5'd2, 4'd6, 4'd7, 19'h20}, 1'b0, 0, 2, 1'b0, 1'b0);
        runTxn({5'd31, 27'h0}, 1'b0, 0, 0, 1'b0, 1'b0);
        runTxn(32'h18918000, 1'b0, TO, 0, 1'b0, 1'b0);
        runTxn({5'd0, 27'h0}, 1'b0, 0, TO, 1'b0, 1'b0);
        runTxn({5'd2, 27'h0}, 1'b0, 0, TO + 1, 1'b0, 1'b0);
        forceStop = 1'b1;
        runTxn(32'h18918000, 1'b0, 0, 0, 1'b1, 1'b0);
        forceStop = 1'b0;
        runTxn({5'd27, 27'h0}, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 250; i++) begin
            logic [31:0] r;
            r = $urandom();
            runTxn(r, coin(), randDelay(), randDelay(), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 7) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
